// File: rtl/mrv32_imm_gen_pipe.sv
// mrv32_imm_gen_pipe -- pipelined immediate generator for the decode stage.
//
// Decodes the immediate selected by in_imm_sel from in_instr, sign/zero
// extends it to XLEN bits and registers it together with an opaque tag.
// The output is a valid/ready stage with a one-entry skid buffer. Because
// in_ready depends only on skid occupancy, it comes straight from a flop and
// has no combinational path from out_ready.
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   flush           synchronous drop of every buffered entry (highest priority)
//   in_valid/ready  input handshake; in_instr, in_imm_sel, in_tag qualify it
//   out_valid/ready output handshake; out_imm, out_tag, out_illegal qualify it
//
// Select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 CSR zimm, 6 shamt, 7 illegal (imm 0).
module mrv32_imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  // Occupancy encoded as {out_valid, skid_valid}; the (0,1) pattern has no
  // enum member because it can never be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b10,
    FULL2 = 2'b11
  } state_t;

  state_t      state_q, state_d;
  entry_t      gen, out_q, skid_q;
  logic [31:0] raw;
  logic        accept, xfer;
  logic        load_out_gen, load_out_skid, load_skid;

  // Every format is first formed as a 32-bit value that is already correctly
  // extended to 32 bits (zero-extended fields have a clear top bit), so a
  // single signed widening covers both XLEN=32 and XLEN=64.
  always_comb begin
    raw         = '0;
    gen.illegal = 1'b0;
    case (in_imm_sel)
      3'd0: raw = {{20{in_instr[31]}}, in_instr[31:20]};
      3'd1: raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'd2: raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      3'd3: raw = {in_instr[31:12], 12'b0};
      3'd4: raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      3'd5: raw = {27'b0, in_instr[19:15]};
      3'd6: raw = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                               : {27'b0, in_instr[24:20]};
      default: gen.illegal = 1'b1;
    endcase
    gen.imm = XLEN'($signed(raw));
    gen.tag = in_tag;
  end

  assign out_valid   = state_q[1];
  assign in_ready    = !state_q[0];
  assign accept      = in_valid && in_ready;
  assign xfer        = out_valid && out_ready;
  assign out_imm     = out_q.imm;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.illegal;

  always_comb begin
    state_d       = state_q;
    load_out_gen  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d      = FULL1;
          load_out_gen = 1'b1;
        end
        FULL1: begin
          if (accept && xfer) begin
            load_out_gen = 1'b1;
          end else if (accept) begin
            state_d   = FULL2;
            load_skid = 1'b1;
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        FULL2: if (xfer) begin
          state_d       = FULL1;
          load_out_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_out_gen)       out_q  <= gen;
      else if (load_out_skid) out_q  <= skid_q;
      if (load_skid)          skid_q <= gen;
    end
  end

endmodule

// File: tb/tb_mrv32_imm_gen_pipe.sv
module tb_mrv32_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_imm_sel = '0;
  logic [31:0] in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  int tests = 0;
  int fails = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  mrv32_imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  mrv32_imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] instr;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transfer log: a handshake in a flush cycle does not count.
  always @(posedge clk)
    if (rst_n && !flush && out_valid32 && out_ready) got.push_back(out_tag32);

  // The (out_valid=0, skid_valid=1) pattern must never appear.
  always @(negedge clk)
    if (rst_n && !out_valid32 && !in_ready32) begin
      tests++;
      fails++;
      $display("FAIL unreachable_state: out_valid 0 with in_ready 0");
    end

  task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] ins,
                       input logic [31:0] tag);
    in_valid   = v;
    in_imm_sel = sel;
    in_instr   = ins;
    in_tag     = tag;
  endtask

  task automatic check_log(input string name, input logic [31:0] exp[$]);
    check({name, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      check({name, "_order"}, 64'(got[k]), 64'(exp[k]));
  endtask

  initial begin
    logic [31:0] hold_tag;
    logic [31:0] hold_imm;
    logic [31:0] exp_q[$];

    vecs[0]  = '{3'd0, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{3'd1, 32'h00112623, 32'h0000000C, 64'h000000000000000C, 1'b0};
    vecs[2]  = '{3'd2, 32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3]  = '{3'd3, 32'h123450B7, 32'h12345000, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{3'd3, 32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[5]  = '{3'd6, 32'h03F00013, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vecs[6]  = '{3'd5, 32'h000F8073, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[7]  = '{3'd7, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[8]  = '{3'd4, 32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[9]  = '{3'd0, 32'h7FF00093, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[10] = '{3'd1, 32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};

    // Reset
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_in_ready", 64'(in_ready32), 64'd1);
    check("rst_out_imm32", 64'(out_imm32), 64'd0);
    check("rst_out_imm64", out_imm64, 64'd0);
    check("rst_out_tag", 64'(out_tag32), 64'd0);
    check("rst_out_illegal", 64'(out_illegal32), 64'd0);
    #10 rst_n = 1'b1;
    step();

    // Streaming with out_ready=1: one result per cycle, 1-cycle latency
    got.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, vecs[k].sel, vecs[k].instr, 32'h100 + k);
      step();
      check($sformatf("vec%0d_valid", k), 64'(out_valid32), 64'd1);
      check($sformatf("vec%0d_imm32", k), 64'(out_imm32), 64'(vecs[k].e32));
      check($sformatf("vec%0d_imm64", k), out_imm64, vecs[k].e64);
      check($sformatf("vec%0d_illegal", k), 64'(out_illegal32), 64'(vecs[k].ill));
      check($sformatf("vec%0d_illegal64", k), 64'(out_illegal64), 64'(vecs[k].ill));
      check($sformatf("vec%0d_tag", k), 64'(out_tag32), 64'(32'h100 + k));
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    check("stream_drain_valid", 64'(out_valid32), 64'd0);
    exp_q.delete();
    for (int k = 0; k < 11; k++) exp_q.push_back(32'h100 + k);
    check_log("stream", exp_q);

    // Backpressure: A, B accepted, C held until skid drains
    got.delete();
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h00A00093, 32'hA);
    step();
    check("bp_in_ready_after_A", 64'(in_ready32), 64'd1);
    drive(1'b1, 3'd0, 32'h00B00093, 32'hB);
    step();
    check("bp_in_ready_after_B", 64'(in_ready32), 64'd0);
    drive(1'b1, 3'd0, 32'h00C00093, 32'hC);
    hold_tag = out_tag32;
    hold_imm = out_imm32;
    check("bp_head_tag", 64'(hold_tag), 64'hA);
    step();
    step();
    check("bp_stable_tag", 64'(out_tag32), 64'(hold_tag));
    check("bp_stable_imm", 64'(out_imm32), 64'(hold_imm));
    check("bp_stall_in_ready", 64'(in_ready32), 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_second_tag", 64'(out_tag32), 64'hB);
    check("bp_in_ready_reopen", 64'(in_ready32), 64'd1);
    step();
    check("bp_third_tag", 64'(out_tag32), 64'hC);
    check("bp_third_imm", 64'(out_imm32), 64'h00C);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    check("bp_drain_valid", 64'(out_valid32), 64'd0);
    exp_q = '{32'hA, 32'hB, 32'hC};
    check_log("bp", exp_q);

    // Simultaneous accept+transfer in FULL1 for 10 cycles
    got.delete();
    drive(1'b1, 3'd3, 32'h12345000, 32'h200);
    step();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 3'd3, 32'h12345000, 32'h200 + k);
      step();
      check($sformatf("sim%0d_in_ready", k), 64'(in_ready32), 64'd1);
      check($sformatf("sim%0d_tag", k), 64'(out_tag32), 64'(32'h200 + k));
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    exp_q.delete();
    for (int k = 0; k <= 10; k++) exp_q.push_back(32'h200 + k);
    check_log("sim", exp_q);

    // Flush in FULL2 together with an input and a transfer
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h0, 32'hD);
    step();
    drive(1'b1, 3'd0, 32'h0, 32'hE);
    step();
    check("fl_full2_in_ready", 64'(in_ready32), 64'd0);
    got.delete();
    drive(1'b1, 3'd0, 32'h0, 32'hF);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("fl_out_valid", 64'(out_valid32), 64'd0);
    check("fl_in_ready", 64'(in_ready32), 64'd1);
    step();
    step();
    check("fl_nothing_emitted", 64'(got.size()), 64'd0);

    // Asynchronous reset in FULL2
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'hFFF00093, 32'h31);
    step();
    drive(1'b1, 3'd0, 32'hFFF00093, 32'h32);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("ar_pre_valid", 64'(out_valid32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid32), 64'd0);
    check("ar_out_imm32", 64'(out_imm32), 64'd0);
    check("ar_out_imm64", out_imm64, 64'd0);
    check("ar_in_ready", 64'(in_ready32), 64'd1);
    step();
    rst_n = 1'b1;
    got.delete();
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 32'h00112623, 32'h40);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("ar_first_valid", 64'(out_valid32), 64'd1);
    check("ar_first_imm", 64'(out_imm32), 64'h0C);
    check("ar_first_tag", 64'(out_tag32), 64'h40);
    step();
    exp_q = '{32'h40};
    check_log("ar", exp_q);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mrv32_imm_gen_pipe.md
Name: mrv32_imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It is the successor to the combinational immediate generator and adds the following:
- XLEN generalisation (32/64).
- CSR zimm and shift-amount formats.
- Illegal-select flagging.
- A sideband tag.
- A registered valid/ready output with a one-entry skid buffer, so decode backpressure never forces a combinational ready path.

It sits between fetch/decode control and the register-read/execute stage.

Parameters:
- XLEN, 32, result width; legal values 32 or 64. Sign extension fills all XLEN bits.
- TAG_W, 32, width of the opaque sideband tag (PC or ROB id) carried alongside each immediate.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops all buffered entries
- in_valid  in  1  instruction/selector valid
- in_ready  out  1  block can accept this cycle
- in_instr  in  32  raw instruction word
- in_imm_sel  in  3  format select
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_imm  out  XLEN  generated immediate
- out_tag  out  TAG_W  tag of that immediate
- out_illegal  out  1  in_imm_sel was unsupported for that entry

Behaviour:
- Reset: clk and rst_n are the only clock/reset. rst_n low asynchronously clears out_valid and skid_valid. It also clears out_imm, out_tag and out_illegal to 0. in_ready is 1 after reset.
- Select encoding (i = in_instr):
  - 0 I: sext(i[31:20])
  - 1 S: sext({i[31:25], i[11:7]})
  - 2 B: sext({i[31], i[7], i[30:25], i[11:8], 0})
  - 3 U: sext({i[31:12], 12'b0}); for XLEN=64, bit 31 fills [63:32]
  - 4 J: sext({i[31], i[19:12], i[20], i[30:21], 0})
  - 5 Z: zext(i[19:15]), CSR zimm
  - 6 SH: zext(i[25:20]) when XLEN=64; zext(i[24:20]) when XLEN=32
  - 7: imm=0, illegal=1
- Formats 0-6 produce illegal=0.
- Generation is pure combinational logic on the input side. The result is registered; latency is 1 cycle from input handshake to out_valid.
- Storage: main output register (out_*) plus one skid register (skid_*).
- Handshakes:
  - Input accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !skid_valid (register-driven, no combinational path from out_ready).
- State, determined by (out_valid, skid_valid):
  - EMPTY (0,0): accept -> FULL1.
  - FULL1 (1,0):
    - Accept and transfer together -> FULL1; the new entry replaces the output register.
    - Accept without transfer -> FULL2; the new entry goes to skid.
    - Transfer only -> EMPTY.
  - FULL2 (1,1): no accept is possible. Transfer -> FULL1, skid moves into the output register, and skid_valid clears.
  - (0,1) is unreachable; verification asserts on it.
- Ordering: strict FIFO. An entry is never dropped or duplicated except by flush.
- While out_valid=1 && out_ready=0, out_imm, out_tag and out_illegal hold stable.
- Flush has priority over every other event in that cycle. It clears out_valid and skid_valid and ignores any simultaneous input or output handshake; the transfer does not count. in_ready is 1 the following cycle.
- Reset asserted mid-operation discards all entries immediately. The block is not sensitive to in_* while rst_n=0.
- The data registers do not need a reset for correctness. They are reset anyway so that the outputs are deterministic.

Test Plan:
1. XLEN=32, stream with out_ready=1:
   - I 0xFFF00093 -> 0xFFFFFFFF
   - S 0x00112623 -> 0x0000000C
   - B 0xFE000EE3 -> 0xFFFFFFFC
   - U 0x123450B7 -> 0x12345000
   - Each output appears exactly 1 cycle after its input, one per cycle.
2. XLEN=64:
   - U 0x800000B7 -> 0xFFFFFFFF80000000
   - SH with i[25:20]=0x3F -> 0x3F
   - Z with i[19:15]=0x1F -> 0x1F
   - sel=7 -> imm 0, out_illegal=1.
3. Backpressure: out_ready=0, present tags A, B, C on consecutive cycles.
   - A and B are accepted; in_ready drops after B and C is held.
   - Raise out_ready: outputs A, B, C in order, none lost; outputs stable while stalled.
4. Simultaneous: in FULL1, assert an accept and a transfer in the same cycle for 10 cycles -> sustained throughput of 1 per cycle, skid never fills.
5. Flush in FULL2 together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, and none of the three entries (the two buffered plus the simultaneous input) ever appears on the output.
6. Assert rst_n=0 asynchronously mid-stream in FULL2 -> out_valid and out_imm go to 0 without a clock edge. After release, the first new input emerges with 1-cycle latency.
